// File: rtl/spmm_pkg.sv
// Shared types and constants for the SpMM output collector.
// Optional K-split accumulation is selected with `define SPMM_OUT_ACC_EN.
package spmm_pkg;
  localparam int unsigned N     = 16;
  localparam int unsigned W     = 8;
  localparam int unsigned LG_N  = $clog2(N);
  localparam int unsigned BEATS = N / 4;
  localparam int unsigned LG_B  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef logic [W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    COLLECT,
    DRAIN
  } state_t;

  // Buffer row written by lane b of beat k.
  function automatic logic [LG_N-1:0] row_addr(input logic [LG_B-1:0] beat, input int unsigned b);
    return LG_N'(4 * 32'(beat) + b);
  endfunction
endpackage

// File: rtl/spmm_tile_buf.sv
// N x N tile buffer: 4-row beat write port (add or overwrite), one combinational
// row read port, synchronous clear. ACC selects accumulate-on-write.
module spmm_tile_buf
  import spmm_pkg::*;
#(
  parameter bit ACC = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    we,
  input  logic [LG_B-1:0]         beat,
  input  logic [3:0][N-1:0][W-1:0] wdata,
  input  logic                    clear,
  input  logic [LG_N-1:0]         raddr,
  output logic [N-1:0][W-1:0]     rdata
);
  logic [N-1:0][N-1:0][W-1:0] mem;
  logic [3:0][N-1:0][W-1:0]   nxt;

  if (ACC) begin : g_acc
    // Element-wise sum; carries out of W bits are dropped.
    always_comb begin
      nxt = '0;
      for (int unsigned b = 0; b < 4; b++) begin
        for (int unsigned c = 0; c < N; c++) begin
          nxt[b][c] = mem[row_addr(beat, b)][c] + wdata[b][c];
        end
      end
    end
  end else begin : g_ovr
    assign nxt = wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem <= '0;
    end else if (clear) begin
      mem <= '0;
    end else if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        mem[row_addr(beat, b)] <= nxt[b];
      end
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/spmm_out_collector.sv
// Drains an N x N SpMM result tile (4 rows/beat) into a local buffer and streams
// it out one row per cycle. `define SPMM_OUT_ACC_EN sums tiles until tile_last.
module spmm_out_collector
  import spmm_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     up_ready,
  output logic                     up_start,
  input  logic [3:0][N-1:0][W-1:0] up_data,
  input  logic                     tile_last,
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic [LG_N-1:0]          row_idx,
  output logic [N-1:0][W-1:0]      row_data,
  output logic                     row_last,
  output logic                     busy
);
`ifdef SPMM_OUT_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  state_t                 state;
  logic [LG_B-1:0]        beat;
  logic                   last_q;
  logic                   drain_due;
  logic                   last_hs;
  logic                   buf_clear;
  logic                   buf_we;
  logic [N-1:0][W-1:0]    rd_row;

  assign drain_due = !ACC || last_q;
  assign last_hs   = (state == DRAIN) && row_ready && (row_idx == LG_N'(N - 1));
  assign buf_clear = ACC && last_hs;
  assign buf_we    = (state == COLLECT);

  spmm_tile_buf #(.ACC(ACC)) u_buf (
    .clock (clock),
    .reset (reset),
    .we    (buf_we),
    .beat  (beat),
    .wdata (up_data),
    .clear (buf_clear),
    .raddr (row_idx),
    .rdata (rd_row)
  );

  // Outside DRAIN the row bus reads zero rather than exposing a partial sum.
  assign row_data = row_valid ? rd_row : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      beat      <= '0;
      last_q    <= 1'b0;
      up_start  <= 1'b0;
      row_valid <= 1'b0;
      row_idx   <= '0;
      row_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (up_ready) begin
            state    <= REQ;
            up_start <= 1'b1;
            busy     <= 1'b1;
            last_q   <= tile_last;
          end
        end
        REQ: begin
          state    <= COLLECT;
          up_start <= 1'b0;
          beat     <= '0;
        end
        COLLECT: begin
          beat <= beat + 1'b1;
          if (beat == LG_B'(BEATS - 1)) begin
            if (drain_due) begin
              state     <= DRAIN;
              row_valid <= 1'b1;
              row_idx   <= '0;
              row_last  <= (N == 1);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (row_ready) begin
            if (row_idx == LG_N'(N - 1)) begin
              state     <= IDLE;
              row_valid <= 1'b0;
              row_idx   <= '0;
              row_last  <= 1'b0;
              busy      <= 1'b0;
            end else begin
              row_idx  <= row_idx + 1'b1;
              row_last <= (row_idx == LG_N'(N - 2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spmm_out_collector.sv
// Self-checking bench for spmm_out_collector: vector table, hand sequences for
// reset/hold corner cases, and random tiles checked against a tile-level model.
module tb_spmm_out_collector;
  import spmm_pkg::*;

`ifdef SPMM_OUT_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif
  localparam int RW = N * W;

  typedef logic [N-1:0][N-1:0][W-1:0] tile_t;
  typedef logic [3:0][N-1:0][W-1:0]   beat_t;

  typedef struct {
    bit          ramp;
    logic [W-1:0] fill;
    bit          last;
    int          rr;
    bit          drain;
    logic [W-1:0] efill;
  } vec_t;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                up_ready = 1'b0;
  logic                up_start;
  beat_t               up_data = '0;
  logic                tile_last = 1'b0;
  logic                row_valid;
  logic                row_ready = 1'b0;
  logic [LG_N-1:0]     row_idx;
  logic [N-1:0][W-1:0] row_data;
  logic                row_last;
  logic                busy;

  tile_t cur_tile, exp_tile, model;
  int    checks = 0;
  int    failures = 0;

  spmm_out_collector dut (
    .clock     (clock),
    .reset     (reset),
    .up_ready  (up_ready),
    .up_start  (up_start),
    .up_data   (up_data),
    .tile_last (tile_last),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_idx   (row_idx),
    .row_data  (row_data),
    .row_last  (row_last),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_up_start"}, RW'(up_start), RW'(0));
    chk({tag, "_row_valid"}, RW'(row_valid), RW'(0));
    chk({tag, "_row_idx"}, RW'(row_idx), RW'(0));
    chk({tag, "_row_data"}, RW'(row_data), RW'(0));
    chk({tag, "_row_last"}, RW'(row_last), RW'(0));
    chk({tag, "_busy"}, RW'(busy), RW'(0));
  endtask

  function automatic beat_t rand_beat();
    beat_t r;
    for (int b = 0; b < 4; b++)
      for (int c = 0; c < N; c++) r[b][c] = W'($urandom);
    return r;
  endfunction

  task automatic fill_const(input logic [W-1:0] v);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) cur_tile[r][c] = v;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) cur_tile[r][c] = W'(16 * r + c);
  endtask

  task automatic fill_rand();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) cur_tile[r][c] = W'($urandom);
  endtask

  // Tile-level reference: accumulate or replace, drain when due, clear after drain.
  task automatic model_tile(input bit last, output bit due);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        model[r][c] = ACC ? W'(model[r][c] + cur_tile[r][c]) : cur_tile[r][c];
    due = !ACC || last;
    if (due) begin
      exp_tile = model;
      if (ACC) model = '0;
    end
  endtask

  // Entered and left on a falling clock edge.
  task automatic run_tile(input bit last, input int rr_mode, input bit hold, input bit drain);
    int hs;
    int cyc;
    bit rr;
    bit ph;
    logic [N-1:0][W-1:0] erow;
    up_ready  = 1'b1;
    tile_last = last;
    @(negedge clock);
    chk("up_start_req", RW'(up_start), RW'(1));
    chk("busy_req", RW'(busy), RW'(1));
    up_ready  = hold;
    tile_last = 1'($urandom);
    for (int k = 0; k < int'(BEATS); k++) begin
      @(negedge clock);
      if (k == 0) chk("up_start_pulse", RW'(up_start), RW'(0));
      chk("row_valid_collect", RW'(row_valid), RW'(0));
      for (int b = 0; b < 4; b++) up_data[b] = cur_tile[4 * k + b];
      if (!hold) up_ready = 1'($urandom);
      row_ready = 1'($urandom);
    end
    @(negedge clock);
    up_data  = rand_beat();
    up_ready = hold;
    if (drain) begin
      hs  = 0;
      cyc = 0;
      ph  = 1'b1;
      while (hs < N && cyc < 400) begin
        erow = exp_tile[hs];
        chk("row_valid", RW'(row_valid), RW'(1));
        chk("row_idx", RW'(row_idx), RW'(hs));
        chk("row_data", RW'(row_data), RW'(erow));
        chk("row_last", RW'(row_last), RW'(hs == N - 1));
        chk("up_start_drain", RW'(up_start), RW'(0));
        case (rr_mode)
          0:       rr = 1'b1;
          1:       rr = ph;
          default: rr = 1'($urandom);
        endcase
        ph = !ph;
        row_ready = rr;
        if (rr) hs++;
        @(negedge clock);
        cyc++;
      end
      if (hs < N) chk("drain_timeout", RW'(hs), RW'(N));
    end
    chk("row_valid_end", RW'(row_valid), RW'(0));
    chk("busy_end", RW'(busy), RW'(0));
    chk("up_start_idle", RW'(up_start), RW'(0));
    row_ready = 1'($urandom);
  endtask

  vec_t vecs[$];
  vec_t v;
  bit   due;
  bit   lst;

  initial begin
    model = '0;
    vecs.push_back('{1'b1, 8'h00, 1'b1, 0, 1'b1, 8'h00});
`ifdef SPMM_OUT_ACC_EN
    vecs.push_back('{1'b0, 8'h01, 1'b0, 0, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 8'hFF, 1'b1, 0, 1'b1, 8'h00});
    vecs.push_back('{1'b0, 8'h05, 1'b1, 1, 1'b1, 8'h05});
    vecs.push_back('{1'b1, 8'h00, 1'b1, 2, 1'b1, 8'h00});
`else
    vecs.push_back('{1'b1, 8'h00, 1'b0, 1, 1'b1, 8'h00});
    vecs.push_back('{1'b0, 8'hC3, 1'b0, 2, 1'b1, 8'hC3});
    vecs.push_back('{1'b0, 8'h5A, 1'b1, 1, 1'b1, 8'h5A});
`endif

    // Reset held with random inputs: all outputs stay zero.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      up_ready  = 1'($urandom);
      tile_last = 1'($urandom);
      row_ready = 1'($urandom);
      up_data   = rand_beat();
      #1 chk_zero("reset");
    end
    @(negedge clock);
    up_ready = 1'b0;
    reset    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("idle_up_start", RW'(up_start), RW'(0));
      chk("idle_busy", RW'(busy), RW'(0));
    end

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.ramp) fill_ramp();
      else fill_const(v.fill);
      model_tile(v.last, due);
      if (v.drain)
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            exp_tile[r][c] = v.ramp ? W'(16 * r + c) : v.efill;
      run_tile(v.last, v.rr, 1'b0, v.drain);
    end

    // Reset after beat 2 of a tile: partial data must not leak into the next tile.
    fill_const(8'hAA);
    up_ready  = 1'b1;
    tile_last = 1'b1;
    @(negedge clock);
    up_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      for (int b = 0; b < 4; b++) up_data[b] = cur_tile[4 * k + b];
    end
    @(negedge clock);
    reset = 1'b0;
    #1 chk_zero("rst_mid");
    @(negedge clock);
    chk_zero("rst_hold");
    reset = 1'b1;
    model = '0;
    fill_const(8'h33);
    model_tile(1'b1, due);
    fill_const(8'h33);
    exp_tile = cur_tile;
    run_tile(1'b1, 0, 1'b0, 1'b1);

    // up_ready held through DRAIN: next REQ one cycle after IDLE.
    fill_ramp();
    model_tile(1'b1, due);
    run_tile(1'b1, 1, 1'b1, due);
    fill_rand();
    model_tile(1'b1, due);
    run_tile(1'b1, 2, 1'b0, due);

    for (int i = 0; i < 12; i++) begin
      fill_rand();
      lst = 1'($urandom);
      model_tile(lst, due);
      run_tile(lst, int'($urandom_range(0, 2)), 1'b0, due);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
